// File: rtl/ntt_pair_gen.sv
// Butterfly index-pair and twiddle-index generator for an N-point Kyber-style NTT.
// Emits linear pairs, forward Cooley-Tukey order, or inverse Gentleman-Sande order.
module ntt_pair_gen #(
  parameter int LOG_N = 8,
  parameter int AW    = LOG_N,
  parameter int OUT_W = 3 * AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] a,
  output logic [AW-1:0]    idx_a,
  output logic [AW-1:0]    idx_b,
  output logic [AW-2:0]    tw,
  output logic [AW-1:0]    stage,
  output logic             busy,
  output logic             done
);

  localparam int N    = 1 << LOG_N;
  localparam int HALF = N / 2;

  localparam logic [1:0] MODE_LIN = 2'd0;
  localparam logic [1:0] MODE_FWD = 2'd1;
  localparam logic [1:0] MODE_INV = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [AW-1:0]    b_q;
  logic [AW-1:0]    s_q;
  logic [OUT_W-1:0] word_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [1:0]       mode_eff;
  logic [AW-1:0]    s_first;
  logic             b_last;
  logic             s_last;
  logic             last_word;
  logic [AW-1:0]    b_nxt;
  logic [AW-1:0]    s_nxt;
  logic             xfer;

  // Packed word {idx_a, idx_b, tw} for butterfly b of stage s. Linear mode is the
  // same pair arithmetic with a span of 1, so idx_a = 2b and idx_b = 2b+1.
  function automatic logic [OUT_W-1:0] pair_word(input logic [1:0]    m,
                                                 input logic [AW-1:0] b,
                                                 input logic [AW-1:0] s);
    logic [AW-1:0] len_log;
    logic [AW-1:0] len;
    logic [AW-1:0] g;
    logic [AW-1:0] off;
    logic [AW-1:0] ia;
    logic [AW-1:0] ib;
    logic [AW-1:0] t;
    if (m == MODE_LIN) len_log = '0;
    else               len_log = AW'(LOG_N - 1) - s;
    len = AW'(1) << len_log;
    g   = b >> len_log;
    off = b & (len - AW'(1));
    ia  = (g << (len_log + AW'(1))) | off;
    ib  = ia + len;
    case (m)
      MODE_FWD: t = (AW'(1) << s) + g;
      MODE_INV: t = (AW'(1) << (s + AW'(1))) - AW'(1) - g;
      default:  t = '0;
    endcase
    return {ia, ib, 1'b0, t[AW-2:0]};
  endfunction

  always_comb begin
    mode_eff = (mode == 2'd3) ? MODE_LIN : mode;
    s_first  = (mode_eff == MODE_INV) ? AW'(LOG_N - 2) : '0;
    xfer     = valid_q && out_ready;
    b_last   = (b_q == AW'(HALF - 1));
    case (mode_q)
      MODE_FWD: s_last = (s_q == AW'(LOG_N - 2));
      MODE_INV: s_last = (s_q == '0);
      default:  s_last = 1'b1;
    endcase
    last_word = b_last && s_last;
    b_nxt     = b_last ? '0 : b_q + AW'(1);
    s_nxt     = s_q;
    if (b_last) begin
      case (mode_q)
        MODE_FWD: s_nxt = s_q + AW'(1);
        MODE_INV: s_nxt = s_q - AW'(1);
        default:  s_nxt = s_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_LIN;
      b_q     <= '0;
      s_q     <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q  <= mode_eff;
            b_q     <= '0;
            s_q     <= s_first;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        // First RUN cycle primes the output register from the loaded counters;
        // afterwards each accepted word advances b (and s at a stage boundary).
        RUN: begin
          if (!valid_q) begin
            word_q  <= pair_word(mode_q, b_q, s_q);
            valid_q <= 1'b1;
          end else if (xfer) begin
            if (last_word) begin
              word_q  <= '0;
              b_q     <= '0;
              s_q     <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              b_q    <= b_nxt;
              s_q    <= s_nxt;
              word_q <= pair_word(mode_q, b_nxt, s_nxt);
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign a         = word_q;
  assign idx_a     = word_q[OUT_W-1 -: AW];
  assign idx_b     = word_q[2*AW-1 -: AW];
  assign tw        = word_q[AW-2:0];
  assign stage     = s_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ntt_pair_gen.sv
// Self-checking bench for ntt_pair_gen: reference NTT loop model feeding a scoreboard,
// plus spot-vector table and hand-written reset/backpressure/latency sequences.
module tb_ntt_pair_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0;
  logic [1:0] mode_s = 2'd0;
  logic rdy_s = 1'b1;
  logic use4 = 1'b0;

  logic start8, start4;
  assign start8 = start_s & ~use4;
  assign start4 = start_s & use4;

  logic        vld8, busy8, done8;
  logic [23:0] a8;
  logic [7:0]  idx_a8, idx_b8, stage8;
  logic [6:0]  tw8;
  logic        vld4, busy4, done4;
  logic [11:0] a4;
  logic [3:0]  idx_a4, idx_b4, stage4;
  logic [2:0]  tw4;

  ntt_pair_gen #(.LOG_N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode_s), .out_ready(rdy_s),
    .out_valid(vld8), .a(a8), .idx_a(idx_a8), .idx_b(idx_b8), .tw(tw8),
    .stage(stage8), .busy(busy8), .done(done8));

  ntt_pair_gen #(.LOG_N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode_s), .out_ready(rdy_s),
    .out_valid(vld4), .a(a4), .idx_a(idx_a4), .idx_b(idx_b4), .tw(tw4),
    .stage(stage4), .busy(busy4), .done(done4));

  always #5 clk = ~clk;

  logic cur_vld, cur_busy, cur_done;
  assign cur_vld  = use4 ? vld4  : vld8;
  assign cur_busy = use4 ? busy4 : busy8;
  assign cur_done = use4 ? done4 : done8;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cap_q[$];

  typedef struct {
    int lg;
    int mode;
    int idx;
    int ia;
    int ib;
    int tw;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int s, input int ia, input int ib, input int t);
    return {s[7:0], ia[7:0], ib[7:0], t[7:0]};
  endfunction

  // Reference: textbook Kyber loops, independent of the per-butterfly arithmetic.
  task automatic push_model(input int lg, input int md);
    int n;
    int k;
    int st;
    n = 1 << lg;
    if (md == 1) begin
      k = 1; st = 0;
      for (int len = n / 2; len >= 2; len = len >> 1) begin
        for (int s0 = 0; s0 < n; s0 += 2 * len) begin
          for (int j = s0; j < s0 + len; j++) exp_q.push_back(pack(st, j, j + len, k));
          k++;
        end
        st++;
      end
    end else if (md == 2) begin
      k = n / 2 - 1; st = lg - 2;
      for (int len = 2; len <= n / 2; len = len << 1) begin
        for (int s0 = 0; s0 < n; s0 += 2 * len) begin
          for (int j = s0; j < s0 + len; j++) exp_q.push_back(pack(st, j, j + len, k));
          k--;
        end
        st--;
      end
    end else begin
      for (int i = 0; i < n / 2; i++) exp_q.push_back(pack(0, 2 * i, 2 * i + 1, 0));
    end
  endtask

  logic        prev_stall8 = 1'b0, prev_stall4 = 1'b0;
  logic [31:0] prev_w8 = '0, prev_w4 = '0;

  always @(negedge clk) begin
    logic [31:0] w;
    if (rst) begin
      prev_stall8 = 1'b0;
    end else begin
      w = {stage8, idx_a8, idx_b8, 1'b0, tw8};
      if (prev_stall8) begin
        check("hold_valid8", 32'(vld8), 32'd1);
        check("hold_word8", w, prev_w8);
      end
      if (vld8 && rdy_s) begin
        check("a_pack8", 32'(a8), 32'({idx_a8, idx_b8, 1'b0, tw8}));
        if (exp_q.size() == 0) check("queue_depth8", 32'(exp_q.size()), 32'd1);
        else check("word8", w, exp_q.pop_front());
        cap_q.push_back(w);
      end
      prev_stall8 = vld8 && !rdy_s;
      prev_w8 = w;
      if (done8) begin
        done_cnt++;
        check("done_excl_valid8", 32'(vld8), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] w;
    if (rst) begin
      prev_stall4 = 1'b0;
    end else begin
      w = {4'd0, stage4, 4'd0, idx_a4, 4'd0, idx_b4, 5'd0, tw4};
      if (prev_stall4) begin
        check("hold_valid4", 32'(vld4), 32'd1);
        check("hold_word4", w, prev_w4);
      end
      if (vld4 && rdy_s) begin
        check("a_pack4", 32'(a4), 32'({idx_a4, idx_b4, 1'b0, tw4}));
        if (exp_q.size() == 0) check("queue_depth4", 32'(exp_q.size()), 32'd1);
        else check("word4", w, exp_q.pop_front());
        cap_q.push_back(w);
      end
      prev_stall4 = vld4 && !rdy_s;
      prev_w4 = w;
      if (done4) begin
        done_cnt++;
        check("done_excl_valid4", 32'(vld4), 32'd0);
      end
    end
  end

  task automatic run_seq(input bit sel4, input logic [1:0] m, input int lg, input int md,
                         input bit rnd, input bit mid_start);
    int  nwords;
    int  gaps;
    bit  seen;
    use4 = sel4;
    exp_q.delete();
    cap_q.delete();
    push_model(lg, md);
    nwords = exp_q.size();
    done_cnt = 0;
    gaps = 0;
    seen = 1'b0;
    rdy_s = 1'b1;
    mode_s = m;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    check("busy_after_start", 32'(cur_busy), 32'd1);
    check("valid_not_yet", 32'(cur_vld), 32'd0);
    @(posedge clk); #1;
    check("first_valid", 32'(cur_vld), 32'd1);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      rdy_s = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_start && cyc == 40) begin
        start_s = 1'b1;
        mode_s = 2'd0;
      end
      @(posedge clk); #1;
      start_s = 1'b0;
      if (cur_busy && !cur_vld) gaps++;
      if (cur_done) begin
        seen = 1'b1;
        break;
      end
    end
    rdy_s = 1'b1;
    check("done_seen", 32'(seen), 32'd1);
    check("busy_low_at_done", 32'(cur_busy), 32'd0);
    check("word_count", 32'(cap_q.size()), 32'(nwords));
    check("leftover", 32'(exp_q.size()), 32'd0);
    check("no_gaps", 32'(gaps), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(cur_done), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    foreach (vecs[i]) begin
      if (vecs[i].lg == lg && vecs[i].mode == md && vecs[i].idx < cap_q.size())
        check($sformatf("vec_lg%0d_m%0d_%0d", lg, md, vecs[i].idx),
              {8'd0, cap_q[vecs[i].idx][23:0]},
              {8'd0, pack(0, vecs[i].ia, vecs[i].ib, vecs[i].tw)} & 32'h00FFFFFF);
    end
  endtask

  task automatic check_zero8(input string nm);
    check({nm, "_valid"}, 32'(vld8), 32'd0);
    check({nm, "_busy"},  32'(busy8), 32'd0);
    check({nm, "_done"},  32'(done8), 32'd0);
    check({nm, "_a"},     32'(a8), 32'd0);
    check({nm, "_idx"},   {idx_a8, idx_b8, stage8, 1'b0, tw8}, 32'd0);
  endtask

  initial begin
    vecs.push_back('{8, 0, 0,   0,   1,   0});
    vecs.push_back('{8, 0, 1,   2,   3,   0});
    vecs.push_back('{8, 0, 127, 254, 255, 0});
    vecs.push_back('{8, 1, 0,   0,   128, 1});
    vecs.push_back('{8, 1, 1,   1,   129, 1});
    vecs.push_back('{8, 1, 128, 0,   64,  2});
    vecs.push_back('{8, 1, 192, 128, 192, 3});
    vecs.push_back('{8, 1, 768, 0,   2,   64});
    vecs.push_back('{8, 1, 895, 253, 255, 127});
    vecs.push_back('{8, 2, 0,   0,   2,   127});
    vecs.push_back('{8, 2, 1,   1,   3,   127});
    vecs.push_back('{8, 2, 2,   4,   6,   126});
    vecs.push_back('{8, 2, 768, 0,   128, 1});
    vecs.push_back('{8, 2, 895, 127, 255, 1});
    vecs.push_back('{4, 1, 0,   0,   8,   1});
    vecs.push_back('{4, 1, 7,   7,   15,  1});
    vecs.push_back('{4, 1, 16,  0,   2,   4});
    vecs.push_back('{4, 1, 23,  13,  15,  7});

    repeat (3) @(posedge clk);
    #1;
    check_zero8("reset");
    check("reset_valid4", 32'(vld4), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a forward run, while word b = 37 is presented.
    use4 = 1'b0;
    exp_q.delete();
    cap_q.delete();
    push_model(8, 1);
    mode_s = 2'd1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int cyc = 0; cyc < 200 && cap_q.size() < 37; cyc++) begin
      @(posedge clk); #1;
    end
    check("mid_word_b37", {8'd0, idx_a8, idx_b8, 1'b0, tw8}, {8'd0, 8'd37, 8'd165, 8'd1});
    rdy_s = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_zero8("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_s = 1'b1;
    @(posedge clk); #1;
    check_zero8("after_reset");

    run_seq(1'b0, 2'd1, 8, 1, 1'b0, 1'b0);
    run_seq(1'b0, 2'd0, 8, 0, 1'b0, 1'b0);
    run_seq(1'b0, 2'd3, 8, 0, 1'b0, 1'b0);
    run_seq(1'b0, 2'd2, 8, 2, 1'b0, 1'b0);
    run_seq(1'b0, 2'd1, 8, 1, 1'b1, 1'b1);
    run_seq(1'b1, 2'd1, 4, 1, 1'b0, 1'b0);
    run_seq(1'b1, 2'd2, 4, 2, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
